// File: rtl/fetch_stage_if.sv
// Bus bundle between the fetch stage, instruction memory, decode and the redirect source.
// The master modport is the fetch stage's view; the slave modport is the environment's view.
interface fetch_stage_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [31:0] pc;

  modport master (
    output imem_req, imem_addr, instr, instr_pc, instr_valid, pc,
    input  imem_ack, imem_rdata, instr_ready, redirect, redirect_pc
  );

  modport slave (
    input  imem_req, imem_addr, instr, instr_pc, instr_valid, pc,
    output imem_ack, imem_rdata, instr_ready, redirect, redirect_pc
  );
endinterface

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, runs a req/ack fetch to instruction memory and holds
// one instruction for decode in a valid/ready output register. Redirects flush held/in-flight data.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input logic           clk,
  input logic           rst_n,
  fetch_stage_if.master bus
);

  typedef enum logic [1:0] {StIdle, StFetch, StDrain} state_e;

  state_e      r_state, w_state_d;
  logic [31:0] r_pc, w_pc_d;
  logic [31:0] r_addr, w_addr_d;
  logic [31:0] r_instr, w_instr_d;
  logic [31:0] r_instr_pc, w_instr_pc_d;
  logic        r_valid, w_valid_d;
  logic        r_kill, w_kill_d;
  logic        r_req;
  logic [31:0] w_redir_pc;

  assign w_redir_pc = bus.redirect_pc & 32'hFFFF_FFFC;

  always_comb begin
    w_state_d    = r_state;
    w_pc_d       = r_pc;
    w_addr_d     = r_addr;
    w_instr_d    = r_instr;
    w_instr_pc_d = r_instr_pc;
    w_valid_d    = r_valid;
    w_kill_d     = r_kill;
    unique case (r_state)
      StIdle: begin
        if (bus.redirect) begin
          w_pc_d   = w_redir_pc;
          w_addr_d = w_redir_pc;
        end else begin
          w_addr_d = r_pc;
        end
        w_state_d = StFetch;
      end
      StFetch: begin
        if (bus.imem_ack) begin
          if (!r_kill && !bus.redirect) begin
            w_instr_d    = bus.imem_rdata;
            w_instr_pc_d = r_addr;
            w_valid_d    = 1'b1;
            w_pc_d       = r_addr + 32'd4;
            w_state_d    = StDrain;
          end else begin
            // Stale or redirected response: drop it and refetch from the new PC.
            w_kill_d = 1'b0;
            if (bus.redirect) w_pc_d = w_redir_pc;
            w_state_d = StIdle;
          end
        end else if (bus.redirect) begin
          w_pc_d   = w_redir_pc;
          w_kill_d = 1'b1;
        end
      end
      StDrain: begin
        if (bus.redirect) begin
          w_valid_d = 1'b0;
          w_pc_d    = w_redir_pc;
          w_state_d = StIdle;
        end else if (bus.instr_ready) begin
          w_valid_d = 1'b0;
          w_state_d = StIdle;
        end
      end
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= StIdle;
      r_pc       <= RESET_PC;
      r_addr     <= RESET_PC;
      r_instr    <= 32'h0;
      r_instr_pc <= 32'h0;
      r_valid    <= 1'b0;
      r_kill     <= 1'b0;
      r_req      <= 1'b0;
    end else begin
      r_state    <= w_state_d;
      r_pc       <= w_pc_d;
      r_addr     <= w_addr_d;
      r_instr    <= w_instr_d;
      r_instr_pc <= w_instr_pc_d;
      r_valid    <= w_valid_d;
      r_kill     <= w_kill_d;
      r_req      <= (w_state_d == StFetch);
    end
  end

  assign bus.imem_req    = r_req;
  assign bus.imem_addr   = r_addr;
  assign bus.instr       = r_instr;
  assign bus.instr_pc    = r_instr_pc;
  assign bus.instr_valid = r_valid;
  assign bus.pc          = r_pc;

endmodule
